// File: rtl/tile_row_gen_pkg.sv
// tile_row_gen_pkg
// Shared definitions for the tile row generator: FSM state encodings,
// column count, counter width, LFSR feedback taps and default seed, plus
// a one-hot to column-index helper.
package tile_row_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNT     = 2'd1,
        ST_WAIT_DRAW = 2'd2
    } state_e;

    localparam int          NUM_COLS     = 4;
    // Wide enough for the largest legal TICK_DIV (2^26-1).
    localparam int          CNT_W        = 26;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [1:0] onehot_to_col(input logic [NUM_COLS-1:0] row);
        logic [1:0] col;
        col = 2'd0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (row[i]) col = 2'(i);
        end
        return col;
    endfunction

endpackage

// File: rtl/tile_row_gen_lfsr.sv
// tile_lfsr16
// Seedable 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left
// with feedback into bit 0. A zero seed would lock the register, so it is
// replaced by 16'h0001.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset, loads the seed
//   step_i  advance the sequence by one step this edge
//   low_o   two least-significant state bits (the column candidate)
module tile_lfsr16
    import tile_row_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    output logic [1:0] low_o
);

    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= SEED_SAFE;
        else       lfsr_q <= lfsr_d;
    end

    assign low_o = lfsr_q[1:0];

endmodule

// File: rtl/tile_row_gen.sv
// tile_row_gen
// Generates one new one-hot 4-column tile row per game tick and keeps a
// 4-deep row history. Advances are held off while the renderer is still
// drawing the previous rows (draw_pending until draw_done).
// Optional build macro TILE_ROW_SPEEDUP_EN: every 16 advances the period
// shrinks by TICK_DIV/8, floored at TICK_DIV/4.
// Ports:
//   CLOCK_50   system clock           reset      async active-high reset
//   enable     game running           draw_done  renderer finished pulse
//   tick       advance pulse          row0..row3 newest..oldest row
//   row_valid  row3 holds a real row  adv_count  advances since reset
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | paused, counter cleared, rows held
// ST_COUNT     | counting toward terminal count of the current period
// ST_WAIT_DRAW | period expired, waiting for draw_done before advancing
module tile_row_gen
    import tile_row_gen_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                draw_done,
    output logic                tick,
    output logic [NUM_COLS-1:0] row0,
    output logic [NUM_COLS-1:0] row1,
    output logic [NUM_COLS-1:0] row2,
    output logic [NUM_COLS-1:0] row3,
    output logic                row_valid,
    output logic [15:0]         adv_count
);

    localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    period;
    logic                pend_q, pend_d, pend_eff;
    logic                advance;
    logic [NUM_COLS-1:0] row0_q, row1_q, row2_q, row3_q;
    logic [NUM_COLS-1:0] row0_d, row1_d, row2_d, row3_d;
    logic [NUM_COLS-1:0] new_row;
    logic                tick_q, tick_d;
    logic                valid_q, valid_d;
    logic [1:0]          fill_q, fill_d;
    logic [15:0]         adv_q, adv_d;
    logic [1:0]          cand, col;

    tile_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .step_i (advance),
        .low_o  (cand)
    );

    // A draw_done arriving with the terminal count already satisfies the
    // outstanding draw, so pending is judged after draw_done is applied.
    assign pend_eff = pend_q & ~draw_done;

`ifdef TILE_ROW_SPEEDUP_EN
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(TICK_DIV / 8);
    localparam logic [CNT_W-1:0] FLOOR = CNT_W'(TICK_DIV / 4);

    logic [CNT_W-1:0] period_q, period_d;

    // Updated on the advance edge; the counter restarts from 0 on that same
    // edge, so the new period governs the very next count.
    always_comb begin
        period_d = period_q;
        if (advance && adv_d[3:0] == 4'd0) begin
            if (period_q < FLOOR + STEP) period_d = FLOOR;
            else                         period_d = period_q - STEP;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) period_q <= DIV;
        else       period_q <= period_d;
    end

    assign period = period_q;
`else
    assign period = DIV;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == period - 1'b1) begin
                    cnt_d = '0;
                    if (pend_eff) state_d = ST_WAIT_DRAW;
                    else          advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DRAW: begin
                cnt_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (draw_done) begin
                    advance = 1'b1;
                    state_d = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bump the candidate column when it repeats the current row0 so that
    // consecutive rows never share a column.
    always_comb begin
        col = cand;
        if (row0_q != '0 && cand == onehot_to_col(row0_q)) col = cand + 2'd1;
        new_row = NUM_COLS'(1) << col;
    end

    always_comb begin
        row0_d  = row0_q;
        row1_d  = row1_q;
        row2_d  = row2_q;
        row3_d  = row3_q;
        adv_d   = adv_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        tick_d  = advance;
        pend_d  = pend_eff;
        if (advance) begin
            row3_d = row2_q;
            row2_d = row1_q;
            row1_d = row0_q;
            row0_d = new_row;
            adv_d  = adv_q + 16'd1;
            pend_d = 1'b1;
            if (fill_q == 2'd3) valid_d = 1'b1;
            else                fill_d  = fill_q + 2'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            row3_q  <= '0;
            tick_q  <= 1'b0;
            valid_q <= 1'b0;
            fill_q  <= 2'd0;
            adv_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
            row3_q  <= row3_d;
            tick_q  <= tick_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
            adv_q   <= adv_d;
        end
    end

    assign tick      = tick_q;
    assign row0      = row0_q;
    assign row1      = row1_q;
    assign row2      = row2_q;
    assign row3      = row3_q;
    assign row_valid = valid_q;
    assign adv_count = adv_q;

endmodule

// File: doc/tile_row_gen.md
Name: tile_row_gen

Overview:
Upstream pattern source for the tile renderers. Generates one new 4-column tile row per game tick and keeps a 4-deep row history. row0 feeds the spawn renderer; row1..row3 feed the three shift renderers. Row advance is gated by a handshake with the renderer, so rows never change while a frame pass is still drawing.

Parameters:
- TICK_DIV, 25000000: CLOCK_50 cycles per row advance (base period). Legal range 4..2^26-1.
- LFSR_SEED, 16'hACE1: LFSR reset value. A zero seed is replaced by 16'h0001.

Ports:
- CLOCK_50  in   1   system clock; all state on rising edge.
- reset     in   1   asynchronous, active-high; clears all state.
- enable    in   1   game running; low pauses generation.
- draw_done in   1   one-cycle pulse from the renderer FSM when all four row renders have finished.
- tick      out  1   one-cycle pulse in the cycle the rows advance.
- row0      out  4   newest row, one-hot; bit n = column n is a target tile.
- row1      out  4   row0 delayed by one advance.
- row2      out  4   row0 delayed by two advances.
- row3      out  4   row0 delayed by three advances (bottom row).
- row_valid out  1   high once row3 holds a generated row (after 4 advances).
- adv_count out  16  number of advances since reset; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, lfsr=LFSR_SEED (0 -> 1), row0..row3=0, tick=0, row_valid=0, adv_count=0, draw_pending=0, fill=0.
- FSM states: IDLE, COUNT, WAIT_DRAW.
- IDLE:
  - enable=1 -> COUNT next cycle, counter=0.
  - Rows are held.
- COUNT:
  - counter increments every cycle.
  - When counter==period-1: counter<=0.
    - If draw_pending=0: advance this edge.
    - Else go to WAIT_DRAW.
  - enable=0 -> IDLE; counter cleared; rows held.
- WAIT_DRAW:
  - counter is held at 0.
  - On draw_done=1: advance on this edge, then return to COUNT.
  - enable=0 -> IDLE; draw_pending is kept.
- draw_pending:
  - Set on every advance; cleared by draw_done.
  - If draw_done and an advance occur in the same cycle, draw_done clears the old pending and the advance sets a new one, so net result is pending=1.
  - In COUNT, if draw_done arrives in the same cycle as the terminal count, it counts as already received and the advance proceeds.
- Advance, one cycle, all registered:
  - tick=1 for exactly that cycle.
  - row3<=row2, row2<=row1, row1<=row0, row0<=new_row.
  - lfsr steps once: Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - adv_count increments.
  - fill (2-bit saturating) increments; row_valid=1 when fill reaches 3 and the 4th advance occurs.
- new_row from the pre-step lfsr value:
  - cand = lfsr[1:0]; prev = column index of row0.
  - If row0!=0 and cand==prev: col = cand+1 mod 4; else col = cand.
  - new_row = 4'b0001 << col.
  - Consecutive rows never share a column.
- period = TICK_DIV, unless modified by the optional feature.
- Outputs are registers; no combinational path from inputs to outputs.

Optional Feature:
TILE_ROW_SPEEDUP_EN.
- Defined: every 16 advances (adv_count[3:0] wraps to 0), period decreases by TICK_DIV/8, floored at TICK_DIV/4. The new period takes effect at the next counter restart. Reset restores period=TICK_DIV.
- Undefined: period is constant TICK_DIV, and no period register is built.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'd0, COUNT=2'd1, WAIT_DRAW=2'd2), NUM_COLS=4, the LFSR tap constant, the default seed.
- One natural sub-module: tile_lfsr16 (seedable 16-bit LFSR with step enable and zero-seed guard). The remaining logic stays in tile_row_gen.

Test Plan (TICK_DIV=4, LFSR_SEED=16'hACE1):
- Reset, enable=1 from cycle 0, draw_done tied high -> first tick on the 4th COUNT cycle. Rows then advance every 4 cycles. row0 is one-hot and never equals the previous row0. row_valid rises with the 4th tick.
- draw_done held low after the first tick -> second terminal count enters WAIT_DRAW; no tick for 20 cycles. A draw_done pulse gives a tick on that edge, and rows shift exactly once.
- draw_done pulse in the same cycle as the terminal count with pending=1 -> tick in that cycle, no WAIT_DRAW entry, draw_pending=1 afterwards.
- enable dropped mid-count (counter=2) -> IDLE, rows and adv_count frozen. Re-enable -> next tick arrives 4 cycles later, confirming the counter restarted.
- Assert reset asynchronously in WAIT_DRAW, between clock edges -> all rows=0, tick=0, adv_count=0, row_valid=0 immediately. The first row after release matches the fresh-reset sequence.
- With TILE_ROW_SPEEDUP_EN and TICK_DIV=64 -> period 64 for advances 1-16, 56 for 17-32, and so on down to a floor of 16. Check the tick spacing at each step.
